// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, SysEx framing bytes, the
// parsed-message record and the parser state encoding.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  // Bytes at or above this value are real-time and never touch the parser.
  localparam logic [7:0] RT_FIRST    = 8'hF8;

  localparam int MSG_W = 22;

  // One complete channel message; mtype is the status high nibble.
  typedef struct packed {
    logic [3:0] mtype;
    logic [3:0] chan;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SYSEX   = 2'd3
  } parser_state_e;

  // Number of data bytes that follow a channel status nibble.
  function automatic logic [1:0] data_len(input logic [3:0] mtype);
    return ((mtype == PROG) || (mtype == CHAN_AT)) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// Show-ahead message FIFO. The head entry is visible on rdata whenever the
// FIFO is not empty; rdata reads as zero when empty. A push while full is
// accepted only if a pop happens in the same cycle.
module midi_msg_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [MSG_W-1:0] wdata,
  input  logic             pop,
  output logic [MSG_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [MSG_W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because rdata is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser with running status, SysEx skipping, real-time
// byte passthrough, channel masking and a show-ahead output message FIFO.
// Output handshake: the head message is transferred on every clock edge
// where msg_valid and msg_ready are both high; msg_* hold while msg_ready=0.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] CH_MASK  = 16'hFFFF,
  parameter bit          VEL0_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [3:0] msg_type,
  output logic [3:0] msg_chan,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2,
  output logic       rt_valid,
  output logic [7:0] rt_code,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [1:0] dbg_state
);

  parser_state_e state_q, state_d;
  logic [7:0]    status_q, status_d;
  logic [6:0]    d1_q, d1_d;
  logic          done;
  midi_msg_t     msg_new;
  logic          push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [MSG_W-1:0] fifo_rdata;
  midi_msg_t     head;
  logic          ovf_evt;

  assign dbg_state = state_q;

  // Parser registers: state, running status and held first data byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      status_q <= '0;
      d1_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  // Next-state decode and message completion for the current byte.
  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    d1_d          = d1_q;
    done          = 1'b0;
    msg_new       = '0;
    msg_new.mtype = status_q[7:4];
    msg_new.chan  = status_q[3:0];
    if (rx_valid) begin
      if (rx_data[7]) begin
        if (rx_data < SYSEX_START) begin
          status_d = rx_data;
          d1_d     = '0;
          state_d  = ST_WAIT_D1;
        end else if (rx_data == SYSEX_START) begin
          status_d = '0;
          d1_d     = '0;
          state_d  = ST_SYSEX;
        end else if (rx_data < RT_FIRST) begin
          // F1..F7: end of SysEx or system common, both leave no running status.
          status_d = '0;
          d1_d     = '0;
          state_d  = ST_IDLE;
        end
      end else begin
        case (state_q)
          ST_WAIT_D1: begin
            if (data_len(status_q[7:4]) == 2'd1) begin
              done       = 1'b1;
              msg_new.d1 = rx_data[6:0];
              msg_new.d2 = '0;
            end else begin
              d1_d    = rx_data[6:0];
              state_d = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            done       = 1'b1;
            msg_new.d1 = d1_q;
            msg_new.d2 = rx_data[6:0];
            state_d    = ST_WAIT_D1;
          end
          default: ;
        endcase
      end
    end
    if (VEL0_OFF && (msg_new.mtype == NOTE_ON) && (msg_new.d2 == 7'd0)) begin
      msg_new.mtype = NOTE_OFF;
    end
  end

  assign push    = done && CH_MASK[msg_new.chan];
  assign ovf_evt = push && fifo_full && !msg_ready;

  midi_msg_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata(msg_new),
    .pop  (msg_ready),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign head      = fifo_rdata;
  assign msg_valid = !fifo_empty;
  assign msg_type  = head.mtype;
  assign msg_chan  = head.chan;
  assign msg_d1    = head.d1;
  assign msg_d2    = head.d2;

  // Real-time bytes: one-cycle pulse, code held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rt_valid <= 1'b0;
      rt_code  <= '0;
    end else begin
      rt_valid <= rx_valid && (rx_data >= RT_FIRST);
      if (rx_valid && (rx_data >= RT_FIRST)) rt_code <= rx_data;
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (ovf_evt) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: table of byte streams with expected messages,
// hand-written FIFO/reset corner sequences, and a randomized stream checked
// against a stream-level reference model.
module tb_midi_msg_parser;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       msg_ready;
  logic       ovf_clr;

  logic       msg_valid, rt_valid, overflow;
  logic [3:0] msg_type, msg_chan;
  logic [6:0] msg_d1, msg_d2;
  logic [7:0] rt_code;
  logic [1:0] dbg_state;

  logic       m_msg_valid, m_rt_valid, m_overflow;
  logic [3:0] m_msg_type, m_msg_chan;
  logic [6:0] m_msg_d1, m_msg_d2;
  logic [7:0] m_rt_code;
  logic [1:0] m_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];
  logic [21:0] exp2_q[$];
  logic [21:0] obs2_q[$];
  logic [7:0]  stim_q[$];
  int          rt_cnt;
  logic [7:0]  rt_last;

  typedef struct packed {
    logic [2:0]       n;
    logic [5:0][7:0]  b;
    logic [1:0]       ne;
    logic [1:0][21:0] e;
    logic [1:0]       nrt;
  } vec_t;

  vec_t vecs [7];

  midi_msg_parser #(.DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type),
    .msg_chan(msg_chan), .msg_d1(msg_d1), .msg_d2(msg_d2),
    .rt_valid(rt_valid), .rt_code(rt_code), .overflow(overflow),
    .ovf_clr(ovf_clr), .dbg_state(dbg_state)
  );

  midi_msg_parser #(.DEPTH(DEPTH), .CH_MASK(16'h0001)) u_mask (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .msg_valid(m_msg_valid), .msg_ready(msg_ready), .msg_type(m_msg_type),
    .msg_chan(m_msg_chan), .msg_d1(m_msg_d1), .msg_d2(m_msg_d2),
    .rt_valid(m_rt_valid), .rt_code(m_rt_code), .overflow(m_overflow),
    .ovf_clr(ovf_clr), .dbg_state(m_dbg_state)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Monitor: record transferred messages and real-time pulses mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (msg_valid && msg_ready)   obs_q.push_back({msg_type, msg_chan, msg_d1, msg_d2});
      if (m_msg_valid && msg_ready) obs2_q.push_back({m_msg_type, m_msg_chan, m_msg_d1, m_msg_d2});
      if (rt_valid) begin
        rt_cnt  = rt_cnt + 1;
        rt_last = rt_code;
      end
    end
  end

  function automatic logic [21:0] mk(input logic [3:0] t, input logic [3:0] c,
                                     input logic [6:0] a, input logic [6:0] b);
    return {t, c, a, b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete(); obs2_q.delete(); exp_q.delete(); exp2_q.delete();
    rt_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard comparison of observed against expected messages
  task automatic compare_q(input string name, input bit masked);
    int ne, no;
    ne = masked ? exp2_q.size() : exp_q.size();
    no = masked ? obs2_q.size() : obs_q.size();
    check({name, " count"}, no, ne);
    for (int i = 0; i < ne && i < no; i++) begin
      if (masked) check({name, " msg"}, obs2_q[i], exp2_q[i]);
      else        check({name, " msg"}, obs_q[i], exp_q[i]);
    end
  endtask

  // Reference model: walk the byte stream, keep running status and a list
  // of collected data bytes, emit when the list reaches the message length.
  task automatic model_run();
    int          st;
    logic [6:0]  d[$];
    int          need;
    logic [3:0]  t, c;
    logic [6:0]  d2;
    logic [21:0] m;
    st = -1;
    foreach (stim_q[i]) begin
      if (stim_q[i] >= 8'hF8) continue;
      if (stim_q[i] >= 8'hF0) begin st = -1; d.delete(); continue; end
      if (stim_q[i] >= 8'h80) begin st = stim_q[i]; d.delete(); continue; end
      if (st < 0) continue;
      d.push_back(stim_q[i][6:0]);
      t = st[7:4];
      c = st[3:0];
      need = (t == 4'hC || t == 4'hD) ? 1 : 2;
      if (d.size() == need) begin
        d2 = (need == 2) ? d[1] : 7'd0;
        if (t == 4'h9 && d2 == 7'd0) t = 4'h8;
        m = mk(t, c, d[0], d2);
        exp_q.push_back(m);
        if (c == 4'd0) exp2_q.push_back(m);
        d.delete();
      end
    end
  endtask

  task automatic set_vec(input int i, input int n, input logic [47:0] bytes_msb_first,
                         input int ne, input logic [21:0] e0, input logic [21:0] e1,
                         input int nrt);
    vecs[i].n   = 3'(n);
    for (int k = 0; k < 6; k++) vecs[i].b[k] = bytes_msb_first[47 - 8*k -: 8];
    vecs[i].ne  = 2'(ne);
    vecs[i].e[0] = e0;
    vecs[i].e[1] = e1;
    vecs[i].nrt = 2'(nrt);
  endtask

  initial begin
    int ebytes;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    msg_ready = 1'b1; ovf_clr = 1'b0;
    rt_cnt = 0; rt_last = 8'h00;

    set_vec(0, 5, 48'h903C643E0000, 2, mk(4'h9,4'h0,7'h3C,7'h64), mk(4'h8,4'h0,7'h3E,7'h00), 0);
    set_vec(1, 4, 48'hB507F8400000, 1, mk(4'hB,4'h5,7'h07,7'h40), 22'h0, 1);
    set_vec(2, 3, 48'hC20506000000, 2, mk(4'hC,4'h2,7'h05,7'h00), mk(4'hC,4'h2,7'h06,7'h00), 0);
    set_vec(3, 5, 48'hF07E01F74500, 0, 22'h0, 22'h0, 0);
    set_vec(4, 2, 48'hD37F00000000, 1, mk(4'hD,4'h3,7'h7F,7'h00), 22'h0, 0);
    set_vec(5, 5, 48'hE10040F11000, 1, mk(4'hE,4'h1,7'h00,7'h40), 22'h0, 0);
    set_vec(6, 5, 48'h8040A5112200, 1, mk(4'hA,4'h5,7'h11,7'h22), 22'h0, 0);

    // Reset state
    do_reset();
    check("rst msg_valid", msg_valid, 0);
    check("rst msg_fields", {msg_type, msg_chan, msg_d1, msg_d2}, 0);
    check("rst rt_valid", rt_valid, 0);
    check("rst rt_code", rt_code, 0);
    check("rst overflow", overflow, 0);

    // Table-driven vectors
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int k = 0; k < int'(vecs[v].n); k++) send_byte(vecs[v].b[k]);
      for (int k = 0; k < int'(vecs[v].ne); k++) exp_q.push_back(vecs[v].e[k]);
      idle(4);
      compare_q($sformatf("vec%0d", v), 1'b0);
      check($sformatf("vec%0d rt", v), rt_cnt, vecs[v].nrt);
    end

    // Real-time pulse timing and hold
    do_reset();
    send_byte(8'h93); send_byte(8'h10); send_byte(8'hFF);
    check("rt pulse", rt_valid, 1);
    check("rt code", rt_code, 8'hFF);
    send_byte(8'h20);
    check("rt pulse end", rt_valid, 0);
    check("rt code hold", rt_code, 8'hFF);
    idle(3);
    exp_q.push_back(mk(4'h9, 4'h3, 7'h10, 7'h20));
    compare_q("rt undisturbed", 1'b0);

    // Overflow with DEPTH+1 messages, latency and head stability
    do_reset();
    msg_ready = 1'b0;
    send_byte(8'h90);
    send_byte(8'h20);
    check("latency before", msg_valid, 0);
    send_byte(8'h40);
    check("latency after", msg_valid, 1);
    for (int k = 1; k <= DEPTH; k++) begin
      send_byte(8'(8'h20 + k)); send_byte(8'h40);
    end
    check("ovf set", overflow, 1);
    check("head held", {msg_type, msg_chan, msg_d1, msg_d2}, mk(4'h9,4'h0,7'h20,7'h40));
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    check("ovf clr", overflow, 0);
    msg_ready = 1'b1;
    idle(DEPTH + 3);
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(mk(4'h9, 4'h0, 7'(7'h20 + k), 7'h40));
    compare_q("ovf drain", 1'b0);

    // Overflow event and clear in the same cycle
    obs_q.delete(); exp_q.delete();
    msg_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      send_byte(8'(8'h30 + k)); send_byte(8'h40);
    end
    send_byte(8'h3F);
    ovf_clr = 1'b1;
    send_byte(8'h40);
    ovf_clr = 1'b0;
    check("ovf wins clr", overflow, 1);
    msg_ready = 1'b1;
    idle(DEPTH + 3);

    // Full FIFO with a pop in the same cycle as the write
    do_reset();
    msg_ready = 1'b0;
    send_byte(8'h90);
    for (int k = 0; k < DEPTH; k++) begin
      send_byte(8'(8'h10 + k)); send_byte(8'h40);
    end
    send_byte(8'(8'h10 + DEPTH));
    msg_ready = 1'b1;
    send_byte(8'h40);
    msg_ready = 1'b0;
    check("full pop ovf", overflow, 0);
    msg_ready = 1'b1;
    idle(DEPTH + 4);
    for (int k = 0; k <= DEPTH; k++) exp_q.push_back(mk(4'h9, 4'h0, 7'(7'h10 + k), 7'h40));
    compare_q("full pop", 1'b0);

    // Reset during a partial message
    do_reset();
    send_byte(8'h80); send_byte(8'h40);
    rst = 1'b1; idle(1); rst = 1'b0;
    send_byte(8'h7F); send_byte(8'h7F);
    idle(3);
    check("rst partial state", dbg_state, 0);
    compare_q("rst partial", 1'b0);

    // Channel mask: channel 1 filtered, channel 0 passes
    do_reset();
    send_byte(8'h91); send_byte(8'h40); send_byte(8'h40);
    send_byte(8'h90); send_byte(8'h41); send_byte(8'h42);
    idle(3);
    exp_q.push_back(mk(4'h9, 4'h1, 7'h40, 7'h40));
    exp_q.push_back(mk(4'h9, 4'h0, 7'h41, 7'h42));
    exp2_q.push_back(mk(4'h9, 4'h0, 7'h41, 7'h42));
    compare_q("mask full", 1'b0);
    compare_q("mask ch0", 1'b1);

    // Randomized stream against the reference model
    do_reset();
    stim_q.delete();
    ebytes = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 20)      b = 8'(8'h80 + $urandom_range(0, 111));
      else if (r < 72) b = 8'($urandom_range(0, 127));
      else if (r < 76) b = 8'hF0;
      else if (r < 80) b = 8'hF7;
      else if (r < 84) b = 8'(8'hF1 + $urandom_range(0, 5));
      else             b = 8'(8'hF8 + $urandom_range(0, 7));
      if (b >= 8'hF8) ebytes++;
      stim_q.push_back(b);
    end
    foreach (stim_q[i]) begin
      send_byte(stim_q[i]);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(5);
    model_run();
    compare_q("rand", 1'b0);
    compare_q("rand mask", 1'b1);
    check("rand rt count", rt_cnt, ebytes);
    for (int i = stim_q.size() - 1; i >= 0; i--) begin
      if (stim_q[i] >= 8'hF8) begin
        check("rand rt last", rt_code, stim_q[i]);
        break;
      end
    end
    check("rand overflow", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
